sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO that succeeds the fixed 8x10 UART buffer. It sits between the UART RX/TX datapaths and the SEC-DED encoder/decoder, and buffers DATA_W-bit codewords. It adds:
- true circular wrap-around
- an occupancy count
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags
- a synchronous flush
- a selectable first-word-fall-through (FWFT) read mode

---
 rtl/sync_fifo_param_if.sv | 32 +++
 rtl/sync_fifo_param.sv | 94 +++++++++
 tb/tb_sync_fifo_param.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - handshake and status bundle for sync_fifo_param
interface sync_fifo_param_if #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              rd_en;
  logic              flush;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output din, wr_en, rd_en, flush, clr_err,
    input  dout, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en, flush, clr_err,
    output dout, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised synchronous FIFO with thresholds, sticky errors, flush and FWFT
module sync_fifo_param #(
  parameter int DATA_W    = 10,
  parameter int DEPTH     = 8,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_param_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_TH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   count_w;
  logic              full_w;
  logic              empty_w;
  logic              wr_acc;
  logic              rd_acc;
  logic              overflow_q;
  logic              underflow_q;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign count_w = wptr - rptr;
  assign full_w  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign empty_w = (wptr == rptr);
  assign wr_acc  = bus.wr_en && !full_w  && !bus.flush;
  assign rd_acc  = bus.rd_en && !empty_w && !bus.flush;

  assign bus.count        = count_w;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_w >= AFULL_C);
  assign bus.almost_empty = (count_w <= AEMPTY_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[ADDR_W-1:0]] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      // A new error in the same cycle as clr_err keeps the flag set.
      if (bus.wr_en && full_w) overflow_q <= 1'b1;
      else if (bus.clr_err)    overflow_q <= 1'b0;
      if (bus.rd_en && empty_w) underflow_q <= 1'b1;
      else if (bus.clr_err)     underflow_q <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dout     = mem[rptr[ADDR_W-1:0]];
      assign bus.rd_valid = !empty_w;
    end else begin : g_reg
      logic [DATA_W-1:0] dout_q;
      logic              rd_valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q     <= '0;
          rd_valid_q <= 1'b0;
        end else if (bus.flush) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rptr[ADDR_W-1:0]];
        end
      end

      assign bus.dout     = dout_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param (registered and FWFT builds)
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(10), .DEPTH(8)) a ();
  sync_fifo_param_if #(.DATA_W(10), .DEPTH(8)) b ();

  sync_fifo_param #(.DATA_W(10), .DEPTH(8), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2))
    u_dut (.clk(clk), .rst(rst), .bus(a.slave));
  sync_fifo_param #(.DATA_W(10), .DEPTH(8), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(2))
    u_fwft (.clk(clk), .rst(rst), .bus(b.slave));

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] sb[$];
  int         mcount   = 0;
  logic       m_ovf    = 1'b0;
  logic       m_unf    = 1'b0;
  logic [9:0] m_dout   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_flags();
    check("count",        32'(a.count),        32'(mcount));
    check("full",         32'(a.full),         32'(mcount == 8));
    check("empty",        32'(a.empty),        32'(mcount == 0));
    check("almost_full",  32'(a.almost_full),  32'(mcount >= 6));
    check("almost_empty", 32'(a.almost_empty), 32'(mcount <= 2));
    check("overflow",     32'(a.overflow),     32'(m_ovf));
    check("underflow",    32'(a.underflow),    32'(m_unf));
  endtask

  task automatic step(input logic wr, input logic rd, input logic [9:0] d,
                      input logic fl, input logic clr);
    logic wa;
    logic ra;
    wa = wr && (mcount != 8);
    ra = rd && (mcount != 0);
    a.din = d; a.wr_en = wr; a.rd_en = rd; a.flush = fl; a.clr_err = clr;
    @(posedge clk);
    #1;
    a.wr_en = 1'b0; a.rd_en = 1'b0; a.flush = 1'b0; a.clr_err = 1'b0;
    if (fl) begin
      sb.delete();
      mcount = 0;
      check("rd_valid_flush", 32'(a.rd_valid), 32'd0);
    end else begin
      if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (wr && mcount == 8) m_ovf = 1'b1;
      if (rd && mcount == 0) m_unf = 1'b1;
      if (wa) sb.push_back(d);
      if (ra) begin
        m_dout = sb.pop_front();
        check("rd_valid", 32'(a.rd_valid), 32'd1);
      end else begin
        check("rd_valid_idle", 32'(a.rd_valid), 32'd0);
      end
      mcount = mcount + int'(wa) - int'(ra);
    end
    check("dout", 32'(a.dout), 32'(m_dout));
    check_flags();
  endtask

  initial begin
    a.din = '0; a.wr_en = 1'b0; a.rd_en = 1'b0; a.flush = 1'b0; a.clr_err = 1'b0;
    b.din = '0; b.wr_en = 1'b0; b.rd_en = 1'b0; b.flush = 1'b0; b.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout",     32'(a.dout),     32'd0);
    check("rst_rd_valid", 32'(a.rd_valid), 32'd0);
    check_flags();
    rst = 1'b0;

    // Fill to full, overflow attempt, drain in order
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 10'(i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 10'h0, 1'b0, 1'b0);

    // Wrap-around: pointers cross the memory end several times
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'(12'h100 + r * 5 + i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 10'h0, 1'b0, 1'b0);
    end

    // Simultaneous access at full, mid-level and empty
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'(12'h200 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 10'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 10'h0AB, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 10'h0CD, 1'b0, 1'b0);
    step(1'b0, 1'b1, 10'h0, 1'b0, 1'b0);

    // Thresholds while filling one word at a time, then error clearing
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'(12'h300 + i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 10'h111, 1'b0, 1'b1);
    step(1'b0, 1'b0, 10'h0, 1'b0, 1'b1);

    // Flush beats concurrent requests and leaves error flags alone
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 10'h155, 1'b1, 1'b0);
    step(1'b0, 1'b1, 10'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 10'h0EE, 1'b0, 1'b0);
    step(1'b0, 1'b1, 10'h0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a write burst
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'(12'h1A0 + i), 1'b0, 1'b0);
    a.din = 10'h1B0; a.wr_en = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete(); mcount = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    check("async_dout",     32'(a.dout),     32'd0);
    check("async_rd_valid", 32'(a.rd_valid), 32'd0);
    check_flags();
    a.wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 10'h0, 1'b0, 1'b0);

    // FWFT build: head word shows without rd_en, rd_en pops
    check("fwft_idle_valid", 32'(b.rd_valid), 32'd0);
    b.din = 10'h2AA; b.wr_en = 1'b1;
    @(posedge clk); #1;
    b.din = 10'h155;
    check("fwft_valid", 32'(b.rd_valid), 32'd1);
    check("fwft_dout",  32'(b.dout),     32'h2AA);
    @(posedge clk); #1;
    b.wr_en = 1'b0;
    check("fwft_head_kept", 32'(b.dout), 32'h2AA);
    b.rd_en = 1'b1;
    @(posedge clk); #1;
    check("fwft_next_dout",  32'(b.dout),     32'h155);
    check("fwft_next_valid", 32'(b.rd_valid), 32'd1);
    @(posedge clk); #1;
    b.rd_en = 1'b0;
    check("fwft_empty",       32'(b.empty),    32'd1);
    check("fwft_empty_valid", 32'(b.rd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
